// File: rtl/fifo_burst_wr_pkg.sv
// fifo_burst_wr_pkg: state encodings and configuration helpers shared by the
// FIFO-to-DDR burst write controller.
package fifo_burst_wr_pkg;

    localparam int unsigned STATE_WIDTH = 2;

    localparam logic [STATE_WIDTH-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_WIDTH-1:0] ST_CMD  = 2'd1;
    localparam logic [STATE_WIDTH-1:0] ST_DATA = 2'd2;

    function automatic int unsigned bytes_per_beat(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned burst_bytes(input int unsigned burst_len,
                                                input int unsigned data_width);
        return burst_len * bytes_per_beat(data_width);
    endfunction

    function automatic int unsigned frame_bursts(input int unsigned frame_beats,
                                                 input int unsigned burst_len);
        return frame_beats / burst_len;
    endfunction

    // Burst length must be a power of two in 2..128 and tile the frame exactly.
    function automatic bit burst_cfg_ok(input int unsigned burst_len,
                                        input int unsigned frame_beats);
        return (burst_len >= 2) && (burst_len <= 128) &&
               ((burst_len & (burst_len - 1)) == 0) &&
               (frame_beats >= burst_len) && ((frame_beats % burst_len) == 0);
    endfunction

endpackage

// File: rtl/burst_rd_skid.sv
// burst_rd_skid: two-entry skid buffer behind a FIFO with one cycle of read
// latency; tracks the read in flight so an issued pop always has a slot.
module burst_rd_skid
    import fifo_burst_wr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_issue,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  pop,
    output logic                  room,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic                  inflight_q;

    assign valid = (count_q != 2'd0);
    assign head  = mem_q[rd_ptr_q];

    // Counting this cycle's departure keeps one pop per cycle under full flow.
    assign room = ((3'(count_q) + 3'(inflight_q) - 3'(pop)) < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd_issue;
            if (inflight_q) begin
                mem_q[wr_ptr_q] <= rd_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(inflight_q) - 2'(pop);
        end
    end

endmodule

// File: rtl/fifo_burst_wr_ctrl.sv
// fifo_burst_wr_ctrl: drains the FIFO read port into fixed-length DDR write
// bursts over a wrapping frame buffer. Define FIFO_BURST_CHK_EN for err_sticky.
module fifo_burst_wr_ctrl
    import fifo_burst_wr_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 64,
    parameter int unsigned           LEVEL_WIDTH = 11,
    parameter int unsigned           ADDR_WIDTH  = 28,
    parameter int unsigned           BURST_LEN   = 16,
    parameter int unsigned           FRAME_BEATS = 14400,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE   = '0
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst,
    input  logic                   frame_start,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_empty,
    input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [ADDR_WIDTH-1:0]  cmd_addr,
    output logic [7:0]             cmd_len,
    output logic                   wdata_valid,
    input  logic                   wdata_ready,
    output logic [DATA_WIDTH-1:0]  wdata,
    output logic                   wdata_last,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   err_sticky
);

    localparam int unsigned BURST_STEP = burst_bytes(BURST_LEN, DATA_WIDTH);
    localparam int unsigned N_BURSTS   = frame_bursts(FRAME_BEATS, BURST_LEN);
    localparam int unsigned PW         = $clog2(BURST_LEN + 1);
    localparam int unsigned BW         = $clog2(BURST_LEN);
    localparam int unsigned FW         = $clog2(N_BURSTS + 1);

    if (!burst_cfg_ok(BURST_LEN, FRAME_BEATS) ||
        ((ADDR_BASE & ADDR_WIDTH'(BURST_STEP - 1)) != '0)) begin : g_cfg_err
        $error("fifo_burst_wr_ctrl: illegal BURST_LEN/FRAME_BEATS/ADDR_BASE");
    end

    logic [STATE_WIDTH-1:0] state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]  cmd_addr_q, cmd_addr_d;
    logic [7:0]             cmd_len_q, cmd_len_d;
    logic [FW-1:0]          fcnt_q, fcnt_d;
    logic [PW-1:0]          pops_q, pops_d;
    logic [BW-1:0]          beats_q, beats_d;
    logic                   restart_q, restart_d;
    logic                   frame_done_q, frame_done_d;

    logic                   skid_room;
    logic                   skid_valid;
    logic [DATA_WIDTH-1:0]  skid_head;
    logic                   beat_acc;
    logic                   last_beat;

    assign beat_acc   = (state_q == ST_DATA) & skid_valid & wdata_ready;
    assign last_beat  = (beats_q == BW'(BURST_LEN - 1));
    assign fifo_rd_en = (state_q == ST_DATA) & (pops_q < PW'(BURST_LEN)) &
                        ~fifo_rd_empty & skid_room;

    burst_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk      (rd_clk),
        .rst      (rd_rst),
        .rd_issue (fifo_rd_en),
        .rd_data  (fifo_rd_data),
        .pop      (beat_acc),
        .room     (skid_room),
        .valid    (skid_valid),
        .head     (skid_head)
    );

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= ADDR_BASE;
            cmd_addr_q   <= '0;
            cmd_len_q    <= '0;
            fcnt_q       <= '0;
            pops_q       <= '0;
            beats_q      <= '0;
            restart_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_len_q    <= cmd_len_d;
            fcnt_q       <= fcnt_d;
            pops_q       <= pops_d;
            beats_q      <= beats_d;
            restart_q    <= restart_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state, address walk, frame wrap and deferred restart.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_len_d    = cmd_len_q;
        fcnt_d       = fcnt_q;
        pops_d       = pops_q;
        beats_d      = beats_q;
        restart_d    = restart_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    addr_d = ADDR_BASE;
                    fcnt_d = '0;
                end
                if ((fifo_rd_water_level >= LEVEL_WIDTH'(BURST_LEN)) && !fifo_rd_empty) begin
                    state_d    = ST_CMD;
                    cmd_addr_d = frame_start ? ADDR_BASE : addr_q;
                    cmd_len_d  = 8'(BURST_LEN - 1);
                    pops_d     = '0;
                    beats_d    = '0;
                end
            end
            ST_CMD: begin
                if (frame_start) restart_d = 1'b1;
                if (cmd_ready) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (frame_start) restart_d = 1'b1;
                if (fifo_rd_en) pops_d = pops_q + PW'(1);
                if (beat_acc) begin
                    beats_d = beats_q + BW'(1);
                    if (last_beat) begin
                        state_d   = ST_IDLE;
                        restart_d = 1'b0;
                        if (restart_q || frame_start) begin
                            addr_d = ADDR_BASE;
                            fcnt_d = '0;
                        end else if (fcnt_q == FW'(N_BURSTS - 1)) begin
                            addr_d       = ADDR_BASE;
                            fcnt_d       = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            addr_d = addr_q + ADDR_WIDTH'(BURST_STEP);
                            fcnt_d = fcnt_q + FW'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_valid   = (state_q == ST_CMD);
    assign cmd_addr    = cmd_addr_q;
    assign cmd_len     = cmd_len_q;
    assign wdata_valid = skid_valid;
    assign wdata       = skid_head;
    assign wdata_last  = skid_valid & last_beat;
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = frame_done_q;

`ifdef FIFO_BURST_CHK_EN
    logic [6:0] starve_q;
    logic       starving;
    logic       err_q;

    assign starving = (state_q == ST_DATA) & (pops_q < PW'(BURST_LEN)) & fifo_rd_empty;

    // Flags 64 consecutive starved cycles mid-burst, or a restart request while busy.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (!starving) begin
                starve_q <= '0;
            end else if (starve_q != 7'd64) begin
                starve_q <= starve_q + 7'd1;
            end
            if ((starving && (starve_q == 7'd63)) || (frame_start && (state_q != ST_IDLE))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_sticky = err_q;
`else
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_burst_wr_ctrl.sv
// tb_fifo_burst_wr_ctrl: directed scoreboard bench for the burst write
// controller with a 4-burst frame and a one-cycle-latency FIFO model.
module tb_fifo_burst_wr_ctrl;

    localparam int unsigned BL = 16;
    localparam int unsigned FB = 4;
`ifdef FIFO_BURST_CHK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic        clk;
    logic        rd_rst;
    logic        frame_start;
    logic        fifo_rd_en;
    logic [63:0] fifo_rd_data;
    logic        fifo_rd_empty;
    logic [10:0] fifo_rd_water_level;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [27:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [63:0] wdata;
    logic        wdata_last;
    logic        busy;
    logic        frame_done;
    logic        err_sticky;

    fifo_burst_wr_ctrl #(
        .FRAME_BEATS (64)
    ) dut (
        .rd_clk              (clk),
        .rd_rst              (rd_rst),
        .frame_start         (frame_start),
        .fifo_rd_en          (fifo_rd_en),
        .fifo_rd_data        (fifo_rd_data),
        .fifo_rd_empty       (fifo_rd_empty),
        .fifo_rd_water_level (fifo_rd_water_level),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_addr            (cmd_addr),
        .cmd_len             (cmd_len),
        .wdata_valid         (wdata_valid),
        .wdata_ready         (wdata_ready),
        .wdata               (wdata),
        .wdata_last          (wdata_last),
        .busy                (busy),
        .frame_done          (frame_done),
        .err_sticky          (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: storage written by the stimulus, popped with one cycle of latency.
    logic [63:0] fmem [1024];
    int          push_cnt;
    int          pop_cnt;

    assign fifo_rd_empty       = (push_cnt == pop_cnt);
    assign fifo_rd_water_level = 11'(push_cnt - pop_cnt);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= fmem[10'(pop_cnt)];
            pop_cnt      <= pop_cnt + 1;
        end
    end

    int          n_chk;
    int          n_bad;
    logic [63:0] exp_q[$];
    logic [27:0] exp_addr_q[$];
    int          beat_idx, cyc_n, t_first, pop_base;
    int          cmd_cnt, done_cnt, fd_seen, fb_idx;
    logic        rand_ready, full_rate, rs_pend, fd_exp, exp_idle;
    logic        hold_v, hold_l;
    logic [63:0] hold_d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_words(input int n);
        logic [63:0] w;
        for (int i = 0; i < n; i++) begin
            w = {32'(push_cnt), 32'($urandom)};
            fmem[10'(push_cnt)] = w;
            exp_q.push_back(w);
            push_cnt++;
        end
    endtask

    // One clock: drive ready at the falling edge, then score everything visible.
    task automatic cyc();
        @(negedge clk);
        wdata_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        cyc_n++;
        chk("rd_en_while_empty", 64'(fifo_rd_en & fifo_rd_empty), 64'd0);
        chk("frame_done", 64'(frame_done), 64'(fd_exp));
        if (frame_done) fd_seen++;
        fd_exp = 1'b0;
        if (exp_idle) chk("idle_after_burst", 64'(busy), 64'd0);
        exp_idle = 1'b0;
        if (hold_v) begin
            chk("hold_valid", 64'(wdata_valid), 64'd1);
            chk("hold_data", wdata, hold_d);
            chk("hold_last", 64'(wdata_last), 64'(hold_l));
        end
        hold_v = wdata_valid & ~wdata_ready;
        hold_d = wdata;
        hold_l = wdata_last;
        if (cmd_valid && cmd_ready) begin
            chk("cmd_expected", 64'(exp_addr_q.size() != 0), 64'd1);
            if (exp_addr_q.size() != 0) chk("cmd_addr", 64'(cmd_addr), 64'(exp_addr_q.pop_front()));
            chk("cmd_len", 64'(cmd_len), 64'(BL - 1));
            pop_base = pop_cnt;
            cmd_cnt++;
        end
        if (wdata_valid && wdata_ready) begin
            chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("wdata", wdata, exp_q.pop_front());
            chk("wdata_last", 64'(wdata_last), 64'(beat_idx == BL - 1));
            if (beat_idx == 0) t_first = cyc_n;
            if (beat_idx == BL - 1) begin
                chk("pops_per_burst", 64'(pop_cnt - pop_base), 64'(BL));
                if (full_rate) chk("back_to_back", 64'(cyc_n - t_first), 64'(BL - 1));
                if (rs_pend) begin
                    rs_pend = 1'b0;
                    fb_idx  = 0;
                end else if (fb_idx == FB - 1) begin
                    fb_idx = 0;
                    fd_exp = 1'b1;
                end else begin
                    fb_idx++;
                end
                exp_idle = 1'b1;
                beat_idx = 0;
                done_cnt++;
            end else begin
                beat_idx++;
            end
        end
    endtask

    task automatic wait_done(input int budget, input string tag);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            cyc();
            n++;
        end
        chk(tag, 64'(done_cnt - start), 64'd1);
    endtask

    task automatic wait_cmd(input int budget, input string tag);
        int start;
        int n;
        start = cmd_cnt;
        n = 0;
        while (cmd_cnt == start && n < budget) begin
            cyc();
            n++;
        end
        chk(tag, 64'(cmd_cnt - start), 64'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
        chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
        chk({tag, "_cmd_addr"}, 64'(cmd_addr), 64'd0);
        chk({tag, "_cmd_len"}, 64'(cmd_len), 64'd0);
        chk({tag, "_wdata_valid"}, 64'(wdata_valid), 64'd0);
        chk({tag, "_wdata"}, wdata, 64'd0);
        chk({tag, "_wdata_last"}, 64'(wdata_last), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        chk({tag, "_err_sticky"}, 64'(err_sticky), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_rst      = 1'b1;
        frame_start = 1'b0;
        cmd_ready   = 1'b1;
        wdata_ready = 1'b1;
        rand_ready  = 1'b0;
        full_rate   = 1'b1;
        rs_pend     = 1'b0;
        fd_exp      = 1'b0;
        exp_idle    = 1'b0;
        hold_v      = 1'b0;
        repeat (3) cyc();
        chk_reset_outputs("reset");
        rd_rst = 1'b0;

        // Level 20: full-rate burst at the frame base.
        exp_addr_q.push_back(28'd0);
        push_words(20);
        wait_done(60, "t1_burst_done");

        // Level 15 must not start a burst; the 16th word does, one cycle later.
        push_words(11);
        repeat (10) begin
            cyc();
            chk("t2_no_cmd", 64'(cmd_valid), 64'd0);
            chk("t2_no_rd_en", 64'(fifo_rd_en), 64'd0);
        end
        exp_addr_q.push_back(28'd128);
        push_words(1);
        cyc();
        chk("t2_cmd_next_cycle", 64'(cmd_valid), 64'd1);
        wait_done(60, "t2_burst_done");

        // Randomly stalled write side.
        full_rate  = 1'b0;
        rand_ready = 1'b1;
        exp_addr_q.push_back(28'd256);
        push_words(16);
        wait_done(300, "t3_burst_done");
        rand_ready = 1'b0;
        full_rate  = 1'b1;

        // Last burst of the frame wraps back to the base with one frame_done.
        exp_addr_q.push_back(28'd384);
        push_words(16);
        wait_done(60, "t4_burst_done");
        cyc();
        chk("t4_frame_done_once", 64'(fd_seen), 64'd1);
        chk("t4_err_clear", 64'(err_sticky), 64'd0);
        exp_addr_q.push_back(28'd0);
        push_words(16);
        wait_done(60, "t4_wrapped_burst_done");

        // frame_start mid-burst: burst completes, restart at base, no frame_done.
        exp_addr_q.push_back(28'd128);
        push_words(16);
        wait_cmd(20, "t5_cmd_seen");
        repeat (5) cyc();
        frame_start = 1'b1;
        rs_pend     = 1'b1;
        cyc();
        frame_start = 1'b0;
        wait_done(60, "t5_burst_done");
        cyc();
        chk("t5_no_frame_done", 64'(fd_seen), 64'd1);
        chk("t5_err_sticky", 64'(err_sticky), 64'(CHK_EN));
        exp_addr_q.push_back(28'd0);
        push_words(16);
        wait_done(60, "t5_restart_burst_done");

        // Reset mid-burst, then a fresh burst from the base with leftover data.
        exp_addr_q.push_back(28'd128);
        push_words(16);
        begin
            int n;
            n = 0;
            while (beat_idx != 7 && n < 100) begin
                cyc();
                n++;
            end
        end
        chk("t6_reach_beat7", 64'(beat_idx), 64'd7);
        rd_rst = 1'b1;
        cyc();
        chk_reset_outputs("t6_reset");
        rd_rst   = 1'b0;
        beat_idx = 0;
        hold_v   = 1'b0;
        exp_idle = 1'b0;
        fd_exp   = 1'b0;
        fb_idx   = 0;
        rs_pend  = 1'b0;
        exp_addr_q.delete();
        exp_q.delete();
        for (int i = pop_cnt; i < push_cnt; i++) exp_q.push_back(fmem[10'(i)]);
        repeat (3) begin
            cyc();
            chk("t6_idle_below_level", 64'(cmd_valid), 64'd0);
        end
        exp_addr_q.push_back(28'd0);
        push_words(16);
        wait_done(60, "t6_burst_done");
        cyc();
        chk("final_frame_done_count", 64'(fd_seen), 64'd1);
        chk("final_cmd_count", 64'(cmd_cnt), 64'd9);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
